// File: rtl/vector_wb_collect.sv
// Writeback collector: gathers per-lane FP16 slices into full vector registers
// in a DEPTH-entry ring and issues completed registers to the VRF write port.
module vector_wb_collect #(
  parameter int NUM_LANES = 16,
  parameter int SLICE_W   = 2,
  parameter int ESZ       = 16,
  parameter int VIDX_W    = 8,
  parameter int DEPTH     = 4
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [NUM_LANES-1:0]             lane_valid,
  output logic [NUM_LANES-1:0]             lane_ready,
  input  logic [NUM_LANES*VIDX_W-1:0]      lane_vd,
  input  logic [NUM_LANES*SLICE_W*ESZ-1:0] lane_result,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [VIDX_W-1:0]                wb_vd,
  output logic [NUM_LANES*SLICE_W*ESZ-1:0] wb_vdata,
  output logic                             vd_err,
  output logic                             busy
);

  localparam int SL_W = SLICE_W * ESZ;
  localparam int VW   = NUM_LANES * SL_W;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [VW-1:0]        data_q    [DEPTH];
  logic [VIDX_W-1:0]    vd_q      [DEPTH];
  logic [NUM_LANES-1:0] done_q    [DEPTH];
  logic [NUM_LANES-1:0] done_nxt  [DEPTH];
  logic [PW-1:0]        lane_wptr [NUM_LANES];
  logic [PW-1:0]        rptr;

  logic [NUM_LANES-1:0] lane_we;
  logic [DEPTH-1:0]     cap_en;
  logic [VIDX_W-1:0]    cap_vd    [DEPTH];
  logic [VIDX_W-1:0]    ref_vd    [DEPTH];
  logic                 err_set;
  logic                 drain;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_ready[l] = ~done_q[lane_wptr[l]][l];
      lane_we[l]    = lane_valid[l] & lane_ready[l];
    end
  end

  assign wb_valid = &done_q[rptr];
  assign wb_vd    = vd_q[rptr];
  assign wb_vdata = data_q[rptr];
  assign drain    = wb_valid & wb_ready;

  always_comb begin
    busy = 1'b0;
    for (int e = 0; e < DEPTH; e++) busy = busy | (|done_q[e]);
  end

  // A fresh entry takes its vd from the lowest-indexed lane writing it;
  // every writer is then compared against the vd the entry will hold.
  always_comb begin
    err_set = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      cap_en[e] = 1'b0;
      cap_vd[e] = '0;
      for (int l = NUM_LANES - 1; l >= 0; l--) begin
        if (lane_we[l] && (lane_wptr[l] == PW'(e))) begin
          cap_en[e] = 1'b1;
          cap_vd[e] = lane_vd[l*VIDX_W +: VIDX_W];
        end
      end
      cap_en[e] = cap_en[e] & (done_q[e] == '0);
      ref_vd[e] = (done_q[e] == '0) ? cap_vd[e] : vd_q[e];
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_we[l] && (lane_vd[l*VIDX_W +: VIDX_W] != ref_vd[lane_wptr[l]]))
        err_set = 1'b1;
    end
  end

  // Drained entry cannot be written the same cycle (its bits gate lane_ready).
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      done_nxt[e] = done_q[e];
      if (drain && (rptr == PW'(e))) done_nxt[e] = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_we[l] && (lane_wptr[l] == PW'(e))) done_nxt[e][l] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int e = 0; e < DEPTH; e++) done_q[e] <= '0;
      for (int l = 0; l < NUM_LANES; l++) lane_wptr[l] <= '0;
      rptr   <= '0;
      vd_err <= 1'b0;
    end else begin
      done_q <= done_nxt;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_we[l]) lane_wptr[l] <= PW'(lane_wptr[l] + 1'b1);
      end
      if (drain) rptr <= PW'(rptr + 1'b1);
      if (err_set) vd_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_we[l]) data_q[lane_wptr[l]][l*SL_W +: SL_W] <= lane_result[l*SL_W +: SL_W];
    end
    for (int e = 0; e < DEPTH; e++) begin
      if (cap_en[e]) vd_q[e] <= cap_vd[e];
    end
  end

endmodule

// File: tb/tb_vector_wb_collect.sv
// Directed bench for vector_wb_collect: alignment, skew, backpressure,
// drain/write collision, vd mismatch, reset and back-to-back throughput.
module tb_vector_wb_collect;

  logic         CLK;
  logic         nRST;
  logic [15:0]  lane_valid;
  logic [15:0]  lane_ready;
  logic [127:0] lane_vd;
  logic [511:0] lane_result;
  logic         wb_valid;
  logic         wb_ready;
  logic [7:0]   wb_vd;
  logic [511:0] wb_vdata;
  logic         vd_err;
  logic         busy;

  int vecs = 0;
  int errs = 0;

  vector_wb_collect dut (
    .CLK(CLK), .nRST(nRST),
    .lane_valid(lane_valid), .lane_ready(lane_ready),
    .lane_vd(lane_vd), .lane_result(lane_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_vd(wb_vd), .wb_vdata(wb_vdata),
    .vd_err(vd_err), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    lane_valid = '0;
  endtask

  task automatic set_lane(input int l, input logic [7:0] vd, input logic [15:0] e0, input logic [15:0] e1);
    lane_valid[l]            = 1'b1;
    lane_vd[l*8 +: 8]        = vd;
    lane_result[l*32 +: 16]  = e0;
    lane_result[l*32+16 +: 16] = e1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; wb_ready = 1'b0; idle(); lane_vd = '0; lane_result = '0;
    tick();
    nRST = 1'b1;
    vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (vd_err !== 1'b0) begin errs++; $display("FAIL reset_vd_err got %b want 0", vd_err); end
    vecs++; if (lane_ready !== 16'hFFFF) begin errs++; $display("FAIL reset_lane_ready got %h want ffff", lane_ready); end
  endtask

  task automatic test_aligned();
    logic [511:0] exp;
    for (int l = 0; l < 16; l++) begin
      set_lane(l, 8'd5, 16'(l), 16'(l + 100));
      exp[(2*l)*16 +: 16]   = 16'(l);
      exp[(2*l+1)*16 +: 16] = 16'(l + 100);
    end
    tick(); idle();
    vecs++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL aligned_valid got %b want 1", wb_valid); end
    vecs++; if (wb_vd !== 8'd5) begin errs++; $display("FAIL aligned_vd got %0d want 5", wb_vd); end
    vecs++; if (wb_vdata !== exp) begin errs++; $display("FAIL aligned_vdata got %h want %h", wb_vdata, exp); end
    vecs++; if (wb_vdata[47:32] !== 16'd1) begin errs++; $display("FAIL aligned_elem2 got %0d want 1", wb_vdata[47:32]); end
    wb_ready = 1'b1;
    tick(); wb_ready = 1'b0;
    vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL aligned_drained_valid got %b want 0", wb_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL aligned_drained_busy got %b want 0", busy); end
  endtask

  task automatic test_skew();
    logic [511:0] exp;
    for (int l = 0; l < 16; l++) begin
      exp[(2*l)*16 +: 16]   = 16'h1000 + 16'(l);
      exp[(2*l+1)*16 +: 16] = 16'h2000 + 16'(l);
    end
    for (int l = 0; l < 8; l++) set_lane(l, 8'd3, 16'h1000 + 16'(l), 16'h2000 + 16'(l));
    tick(); idle();
    for (int c = 1; c <= 4; c++) begin
      vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL skew_valid_c%0d got %b want 0", c, wb_valid); end
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL skew_busy_c%0d got %b want 1", c, busy); end
      if (c == 4) for (int l = 8; l < 16; l++) set_lane(l, 8'd3, 16'h1000 + 16'(l), 16'h2000 + 16'(l));
      tick(); idle();
    end
    vecs++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL skew_valid_c5 got %b want 1", wb_valid); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL skew_busy_c5 got %b want 1", busy); end
    vecs++; if (wb_vd !== 8'd3) begin errs++; $display("FAIL skew_vd got %0d want 3", wb_vd); end
    vecs++; if (wb_vdata !== exp) begin errs++; $display("FAIL skew_vdata got %h want %h", wb_vdata, exp); end
    wb_ready = 1'b1;
    tick(); wb_ready = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL skew_drained_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_lane(0, 8'(k), 16'h0A00 + 16'(k), 16'h0B00 + 16'(k));
      vecs++; if (lane_ready[0] !== (k <= 4)) begin errs++; $display("FAIL bp_ready0_k%0d got %b want %b", k, lane_ready[0], (k <= 4)); end
      vecs++; if (lane_ready[15:1] !== 15'h7FFF) begin errs++; $display("FAIL bp_others_k%0d got %h want 7fff", k, lane_ready[15:1]); end
      tick();
    end
    idle();
    vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL bp_partial_valid got %b want 0", wb_valid); end
    for (int k = 1; k <= 4; k++) begin
      for (int l = 1; l < 16; l++) set_lane(l, 8'(k), 16'h0C00 + 16'(k), 16'h0D00 + 16'(l));
      tick();
    end
    idle();
    vecs++; if (lane_ready !== 16'h0000) begin errs++; $display("FAIL bp_full_ready got %h want 0000", lane_ready); end
    wb_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      vecs++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL bp_drain_valid_k%0d got %b want 1", k, wb_valid); end
      vecs++; if (wb_vd !== 8'(k)) begin errs++; $display("FAIL bp_drain_vd_k%0d got %0d want %0d", k, wb_vd, k); end
      vecs++; if (wb_vdata[15:0] !== 16'h0A00 + 16'(k)) begin errs++; $display("FAIL bp_drain_elem0_k%0d got %h want %h", k, wb_vdata[15:0], 16'h0A00 + 16'(k)); end
      tick();
    end
    wb_ready = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL bp_end_busy got %b want 0", busy); end
  endtask

  task automatic test_same_cycle();
    wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 16; l++) set_lane(l, 8'(10 + k), 16'(k), 16'(l));
      tick();
    end
    idle();
    vecs++; if (lane_ready !== 16'h0000) begin errs++; $display("FAIL sc_full_ready got %h want 0000", lane_ready); end
    vecs++; if (wb_vd !== 8'd10) begin errs++; $display("FAIL sc_head_vd got %0d want 10", wb_vd); end
    set_lane(3, 8'd14, 16'hBEEF, 16'hCAFE);
    wb_ready = 1'b1;
    vecs++; if (lane_ready[3] !== 1'b0) begin errs++; $display("FAIL sc_drain_cycle_ready3 got %b want 0", lane_ready[3]); end
    tick(); wb_ready = 1'b0;
    vecs++; if (lane_ready[3] !== 1'b1) begin errs++; $display("FAIL sc_next_cycle_ready3 got %b want 1", lane_ready[3]); end
    vecs++; if (wb_vd !== 8'd11) begin errs++; $display("FAIL sc_head_after_drain got %0d want 11", wb_vd); end
    tick(); idle();
    vecs++; if (lane_ready[3] !== 1'b0) begin errs++; $display("FAIL sc_after_write_ready3 got %b want 0", lane_ready[3]); end
    vecs++; if (lane_ready[0] !== 1'b1) begin errs++; $display("FAIL sc_ready0 got %b want 1", lane_ready[0]); end
    for (int l = 0; l < 16; l++) if (l != 3) set_lane(l, 8'd14, 16'h0001, 16'h0002);
    wb_ready = 1'b1;
    for (int k = 11; k <= 13; k++) begin
      vecs++; if (wb_vd !== 8'(k)) begin errs++; $display("FAIL sc_drain_vd got %0d want %0d", wb_vd, k); end
      tick(); idle();
    end
    vecs++; if (wb_vd !== 8'd14) begin errs++; $display("FAIL sc_last_vd got %0d want 14", wb_vd); end
    vecs++; if (wb_vdata[111:96] !== 16'hBEEF) begin errs++; $display("FAIL sc_lane3_elem got %h want beef", wb_vdata[111:96]); end
    tick(); wb_ready = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL sc_end_busy got %b want 0", busy); end
    vecs++; if (vd_err !== 1'b0) begin errs++; $display("FAIL sc_vd_err got %b want 0", vd_err); end
  endtask

  task automatic test_vd_mismatch();
    set_lane(0, 8'd2, 16'h1, 16'h2);
    set_lane(9, 8'd7, 16'h3, 16'h4);
    tick(); idle();
    vecs++; if (vd_err !== 1'b1) begin errs++; $display("FAIL mm_vd_err got %b want 1", vd_err); end
    for (int l = 0; l < 16; l++) if (l != 0 && l != 9) set_lane(l, 8'd2, 16'h5, 16'h6);
    tick(); idle();
    vecs++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL mm_valid got %b want 1", wb_valid); end
    vecs++; if (wb_vd !== 8'd2) begin errs++; $display("FAIL mm_wb_vd got %0d want 2", wb_vd); end
    wb_ready = 1'b1;
    tick(); wb_ready = 1'b0;
    tick();
    vecs++; if (vd_err !== 1'b1) begin errs++; $display("FAIL mm_vd_err_held got %b want 1", vd_err); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] exp;
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 8'(20 + k), 16'h7, 16'h8);
      set_lane(5, 8'(20 + k), 16'h7, 16'h8);
      tick();
    end
    idle();
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rm_busy_before got %b want 1", busy); end
    nRST = 1'b0;
    tick(); nRST = 1'b1;
    vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL rm_valid got %b want 0", wb_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rm_busy got %b want 0", busy); end
    vecs++; if (lane_ready !== 16'hFFFF) begin errs++; $display("FAIL rm_ready got %h want ffff", lane_ready); end
    vecs++; if (vd_err !== 1'b0) begin errs++; $display("FAIL rm_vd_err got %b want 0", vd_err); end
    for (int l = 0; l < 16; l++) begin
      set_lane(l, 8'd9, 16'h3000 + 16'(l), 16'h4000 + 16'(l));
      exp[(2*l)*16 +: 16]   = 16'h3000 + 16'(l);
      exp[(2*l+1)*16 +: 16] = 16'h4000 + 16'(l);
    end
    tick(); idle();
    vecs++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL rm_fresh_valid got %b want 1", wb_valid); end
    vecs++; if (wb_vd !== 8'd9) begin errs++; $display("FAIL rm_fresh_vd got %0d want 9", wb_vd); end
    vecs++; if (wb_vdata !== exp) begin errs++; $display("FAIL rm_fresh_vdata got %h want %h", wb_vdata, exp); end
    wb_ready = 1'b1;
    tick(); wb_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int l = 0; l < 16; l++) set_lane(l, 8'(30 + k), 16'(k), 16'(l));
      if (k > 0) begin
        vecs++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid_k%0d got %b want 1", k, wb_valid); end
        vecs++; if (wb_vd !== 8'(29 + k)) begin errs++; $display("FAIL b2b_vd_k%0d got %0d want %0d", k, wb_vd, 29 + k); end
      end
      vecs++; if (lane_ready !== 16'hFFFF) begin errs++; $display("FAIL b2b_ready_k%0d got %h want ffff", k, lane_ready); end
      tick();
    end
    idle();
    vecs++; if (wb_vd !== 8'd35) begin errs++; $display("FAIL b2b_last_vd got %0d want 35", wb_vd); end
    tick(); wb_ready = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_end_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_skew();
    test_backpressure();
    test_same_cycle();
    test_back_to_back();
    test_vd_mismatch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/vector_wb_collect.md
# vector_wb_collect

Writeback collector between the 16 vector lanes and the VEGGIE vector register file write port. Each lane delivers its 2-element FP16 slice of a result independently, in program order per lane but skewed across lanes by functional-unit latency. The block assembles slices into full 32-element vector registers in a DEPTH-entry ring and issues each completed register, with its destination index, to one VEGGIE write port through a valid/ready handshake.

## Interface
- NUM_LANES, 16, lane count
- SLICE_W, 2, elements per lane slice
- ESZ, 16, element width in bits
- VIDX_W, 8, vector register index width
- DEPTH, 4, assembly entries (power of two, ≥2)
- CLK  in  1  clock, all logic on rising edge
- nRST  in  1  synchronous active-low reset
- lane_valid  in  NUM_LANES  per-lane result valid
- lane_ready  out  NUM_LANES  per-lane accept
- lane_vd  in  NUM_LANES×VIDX_W  per-lane destination register
- lane_result  in  NUM_LANES×SLICE_W×ESZ  per-lane slice; lane l supplies elements l*SLICE_W..l*SLICE_W+SLICE_W-1
- wb_valid  out  1  completed register available
- wb_ready  in  1  VEGGIE write port accepts
- wb_vd  out  VIDX_W  destination register of head entry
- wb_vdata  out  NUM_LANES×SLICE_W×ESZ  assembled register, element 0 in LSBs
- vd_err  out  1  sticky: lanes disagreed on vd within one entry
- busy  out  1  any entry holds at least one slice

## Operation
- Storage per entry: data (512 b), vd, done bitmap (NUM_LANES bits). Per-lane write pointer lane_wptr[l] (log2 DEPTH bits); one read pointer rptr.
- Lane accept: lane_ready[l] = ~done[lane_wptr[l]][l], from registered state only. Lane write occurs when lane_valid[l] & lane_ready[l].
- On lane write: slice into entry lane_wptr[l] at lane l's position, set done bit, lane_wptr[l] increments modulo DEPTH.
- Entry vd capture: if entry's done bitmap was all-zero before this cycle, vd := lane_vd of lowest-indexed lane writing that entry this cycle. Any other lane writing the same entry (same or later cycle) with a different vd sets vd_err; vd_err clears only on reset. Stored vd is never overwritten.
- Head complete: wb_valid = &done[rptr]; wb_vd/wb_vdata driven combinationally from entry rptr.
- Drain: wb_valid & wb_ready clears done[rptr] (data/vd need not clear), rptr increments modulo DEPTH.
- Full/backpressure: lane l stalls when its target entry still holds its slice (lane is DEPTH entries ahead of rptr). Lanes never block each other except through this rule.
- Drain and lane write to the drained entry in the same cycle: lane_ready was low (bit set), so no write; write accepted next cycle.
- Drain of entry rptr and lane writes to other entries in the same cycle: all take effect.
- busy = |(all done bits).
- Reset (nRST=0 at edge): all done bits 0, all lane_wptr 0, rptr 0, vd_err 0. Outputs after reset: wb_valid 0, busy 0, vd_err 0, lane_ready all 1; wb_vd/wb_vdata don't-care while wb_valid 0. Reset mid-operation discards all partial and complete entries.

## Timing
- Lane write at edge N; done bit visible from cycle N+1.
- Last slice written at edge N → wb_valid high in cycle N+1 (1-cycle latency, no bypass).
- wb_valid, once high, stays high with stable wb_vd/wb_vdata until drained.
- Sustained throughput: one register per cycle when all lanes deliver every cycle and wb_ready=1.
- Freed lane slot usable the cycle after drain.

## Test plan
- Aligned: all 16 lanes valid in cycle 0, vd=5, lane l result={l,l+100} → cycle 1 wb_valid=1, wb_vd=5, element 2l=l, 2l+1=l+100; wb_ready=1 → cycle 2 wb_valid=0, busy=0.
- Skew: lanes 0–7 write vd=3 in cycle 0, lanes 8–15 in cycle 4 → wb_valid low cycles 1–4, high cycle 5; busy high cycles 1–5.
- Backpressure: wb_ready=0, lane 0 valid every cycle with vd=1..5, other lanes idle → lane_ready[0] drops after 4 accepts; others stay 1; raising wb_ready with full entries drains 4 registers vd=1..4 in order after remaining lanes fill them.
- Same-cycle drain/write: ring full for lane 3 at rptr; wb_ready=1 → lane 3 accepted the following cycle, not the drain cycle.
- vd mismatch: lane 0 vd=2, lane 9 vd=7 into the same entry → vd_err=1 next cycle, entry wb_vd=2, vd_err held until reset.
- Reset mid-operation: 3 entries partially filled, nRST=0 one cycle → wb_valid=0, busy=0, lane_ready=all 1, vd_err=0; fresh aligned write completes with wb_vd correct.
